// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hs/vs/de + pixel coordinates) for
// the HDMI path, in C64 NTSC or PAL geometry. Counters are re-aligned to the
// upper-left corner of active video by the analyzer's vreset pulse.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   ce       pixel clock enable
//   mode     analyzer mode (1 = PAL, anything else = NTSC geometry)
//   vreset   resync pulse, forces counters to (0,0), sampled every clk
//   hs, vs   active-low syncs (falling edge = start of sync)
//   de       active video
//   hcnt     pixel x, aligned with hs/vs/de
//   vcnt     line y, aligned with hs/vs/de
//   sof      start-of-frame pulse, one clk wide
module video_timing_gen #(
    parameter int unsigned H_ACTIVE      = 384,
    parameter int unsigned HS_START      = 416,
    parameter int unsigned HS_WIDTH      = 32,
    parameter int unsigned NTSC_H_TOTAL  = 520,
    parameter int unsigned PAL_H_TOTAL   = 504,
    parameter int unsigned NTSC_V_TOTAL  = 263,
    parameter int unsigned PAL_V_TOTAL   = 312,
    parameter int unsigned NTSC_V_ACTIVE = 235,
    parameter int unsigned PAL_V_ACTIVE  = 284,
    parameter int unsigned NTSC_VS_START = 245,
    parameter int unsigned PAL_VS_START  = 295,
    parameter int unsigned VS_LINES      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [1:0] mode,
    input  logic       vreset,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       sof
);

    localparam int unsigned CW = 10;

    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG     = CW'(HS_START);
    localparam logic [CW-1:0] HS_END     = CW'(HS_START + HS_WIDTH);
    localparam logic [CW-1:0] NTSC_H_LST = CW'(NTSC_H_TOTAL - 1);
    localparam logic [CW-1:0] PAL_H_LST  = CW'(PAL_H_TOTAL - 1);
    localparam logic [CW-1:0] NTSC_V_LST = CW'(NTSC_V_TOTAL - 1);
    localparam logic [CW-1:0] PAL_V_LST  = CW'(PAL_V_TOTAL - 1);
    localparam logic [CW-1:0] NTSC_V_ACT = CW'(NTSC_V_ACTIVE);
    localparam logic [CW-1:0] PAL_V_ACT  = CW'(PAL_V_ACTIVE);
    localparam logic [CW-1:0] NTSC_VS_B  = CW'(NTSC_VS_START);
    localparam logic [CW-1:0] PAL_VS_B   = CW'(PAL_VS_START);
    localparam logic [CW-1:0] NTSC_VS_E  = CW'(NTSC_VS_START + VS_LINES);
    localparam logic [CW-1:0] PAL_VS_E   = CW'(PAL_VS_START + VS_LINES);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          amode;
    logic          at_origin;

    logic [CW-1:0] h_last;
    logic [CW-1:0] v_last;
    logic [CW-1:0] v_act;
    logic [CW-1:0] vs_beg;
    logic [CW-1:0] vs_end;
    logic          h_wrap;
    logic          v_wrap;
    logic          pal_req;
    logic          origin;

    // Geometry of the frame in progress, selected by the latched mode only
    always_comb begin
        h_last = NTSC_H_LST;
        v_last = NTSC_V_LST;
        v_act  = NTSC_V_ACT;
        vs_beg = NTSC_VS_B;
        vs_end = NTSC_VS_E;
        if (amode) begin
            h_last = PAL_H_LST;
            v_last = PAL_V_LST;
            v_act  = PAL_V_ACT;
            vs_beg = PAL_VS_B;
            vs_end = PAL_VS_E;
        end
    end

    assign h_wrap  = (hc == h_last);
    assign v_wrap  = (vc == v_last);
    assign pal_req = (mode == 2'd1);
    assign origin  = (hc == '0) && (vc == '0);

    // Raster counters; vreset wins over increment and wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc    <= '0;
            vc    <= '0;
            amode <= 1'b0;
        end else if (vreset) begin
            hc    <= '0;
            vc    <= '0;
            amode <= pal_req;
        end else if (ce) begin
            if (h_wrap) begin
                hc <= '0;
                if (v_wrap) begin
                    vc    <= '0;
                    amode <= pal_req;
                end else begin
                    vc <= vc + CW'(1);
                end
            end else begin
                hc <= hc + CW'(1);
            end
        end
    end

    // Output stage, one ce-qualified clk behind the counters.
    // at_origin suppresses repeat sof while a held vreset parks us at (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            hs        <= 1'b1;
            vs        <= 1'b1;
            de        <= 1'b0;
            sof       <= 1'b0;
            at_origin <= 1'b0;
        end else begin
            sof <= 1'b0;
            if (ce) begin
                hcnt      <= hc;
                vcnt      <= vc;
                de        <= (hc < H_ACT) && (vc < v_act);
                hs        <= !((hc >= HS_BEG) && (hc < HS_END));
                vs        <= !((vc >= vs_beg) && (vc < vs_end));
                sof       <= origin && !at_origin;
                at_origin <= origin;
            end
        end
    end

endmodule
